// File: rtl/mem_stage.sv
// MEM stage: data memory access with configurable latency, branch resolve,
// and MEM/WB register. Stalls upstream while a multi-cycle access is pending.
//
// Ports:
//   clock, reset (sync, active-low)
//   EXMEM_wb, EXMEM_m, EXMEM_branchTarget, EXMEM_zero,
//   EXMEM_aluResult, EXMEM_memWriteData, EXMEM_writeReg  (from EX/MEM)
//   pcSrc, branchTarget                                 (comb branch resolve)
//   mem_stall                                           (comb upstream hold)
//   MEMWB_wb, MEMWB_readData, MEMWB_aluResult,
//   MEMWB_writeReg                                      (registered to WB)
module mem_stage #(
  parameter int ADDR_BITS   = 10,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  EXMEM_wb,
  input  logic [2:0]  EXMEM_m,
  input  logic [31:0] EXMEM_branchTarget,
  input  logic        EXMEM_zero,
  input  logic [31:0] EXMEM_aluResult,
  input  logic [31:0] EXMEM_memWriteData,
  input  logic [4:0]  EXMEM_writeReg,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic        mem_stall,
  output logic [1:0]  MEMWB_wb,
  output logic [31:0] MEMWB_readData,
  output logic [31:0] MEMWB_aluResult,
  output logic [4:0]  MEMWB_writeReg
);

  localparam int   DEPTH = 1 << ADDR_BITS;
  localparam logic MULTI = (MEM_LATENCY > 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state;
  logic [31:0] cnt;

  logic [31:0] mem [DEPTH];

  logic                 branch;
  logic                 mem_read;
  logic                 mem_write;
  logic                 access;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          rd_word;
  logic                 done;
  logic                 stall;

  assign branch    = EXMEM_m[2];
  assign mem_read  = EXMEM_m[1];
  assign mem_write = EXMEM_m[0];
  assign access    = mem_read | mem_write;

  // Word addressing: byte offset and upper bits dropped, so
  // addresses wrap modulo the memory size.
  assign idx     = EXMEM_aluResult[ADDR_BITS+1:2];
  assign rd_word = mem[idx];

  logic unused_addr;
  assign unused_addr = ^{EXMEM_aluResult[31:ADDR_BITS+2],
                         EXMEM_aluResult[1:0]};

  assign pcSrc        = branch & EXMEM_zero;
  assign branchTarget = EXMEM_branchTarget;

  // done marks the edge on which the access retires; stall marks
  // every edge before it.
  always_comb begin
    done  = 1'b0;
    stall = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        stall = access & MULTI;
        done  = access & ~MULTI;
      end
      (state == BUSY): begin
        stall = (cnt != 32'd0);
        done  = (cnt == 32'd0);
      end
    endcase
  end

  assign mem_stall = stall;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access && MULTI) begin
            state <= BUSY;
            cnt   <= 32'(MEM_LATENCY - 2);
          end
        end
        BUSY: begin
          if (cnt == 32'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
      endcase
    end
  end

  // Stalled edges insert a bubble by clearing wb only; the data
  // fields hold. readData sees the pre-write word on read+write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      MEMWB_wb        <= 2'b00;
      MEMWB_readData  <= 32'd0;
      MEMWB_aluResult <= 32'd0;
      MEMWB_writeReg  <= 5'd0;
    end else if (stall) begin
      MEMWB_wb <= 2'b00;
    end else begin
      MEMWB_wb        <= EXMEM_wb;
      MEMWB_aluResult <= EXMEM_aluResult;
      MEMWB_writeReg  <= EXMEM_writeReg;
      MEMWB_readData  <= mem_read ? rd_word : 32'd0;
    end
  end

  // Contents survive reset; reset only blocks a pending store.
  always_ff @(posedge clock) begin
    if (reset && done && mem_write) begin
      mem[idx] <= EXMEM_memWriteData;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: latency-2 and latency-4 instances
// share inputs and are exercised one at a time via separate resets.
module tb_mem_stage;

  logic        clock;
  logic        reset2;
  logic        reset4;
  logic [1:0]  wb;
  logic [2:0]  m;
  logic [31:0] target;
  logic        zero;
  logic [31:0] alu;
  logic [31:0] wdata;
  logic [4:0]  wreg;

  logic        pc2, pc4;
  logic [31:0] bt2, bt4;
  logic        st2, st4;
  logic [1:0]  owb2, owb4;
  logic [31:0] ord2, ord4;
  logic [31:0] oal2, oal4;
  logic [4:0]  owr2, owr4;

  int vectors;
  int miscompares;

  mem_stage #(.ADDR_BITS(10), .MEM_LATENCY(2)) u2 (
    .clock(clock), .reset(reset2),
    .EXMEM_wb(wb), .EXMEM_m(m),
    .EXMEM_branchTarget(target), .EXMEM_zero(zero),
    .EXMEM_aluResult(alu), .EXMEM_memWriteData(wdata),
    .EXMEM_writeReg(wreg),
    .pcSrc(pc2), .branchTarget(bt2), .mem_stall(st2),
    .MEMWB_wb(owb2), .MEMWB_readData(ord2),
    .MEMWB_aluResult(oal2), .MEMWB_writeReg(owr2)
  );

  mem_stage #(.ADDR_BITS(10), .MEM_LATENCY(4)) u4 (
    .clock(clock), .reset(reset4),
    .EXMEM_wb(wb), .EXMEM_m(m),
    .EXMEM_branchTarget(target), .EXMEM_zero(zero),
    .EXMEM_aluResult(alu), .EXMEM_memWriteData(wdata),
    .EXMEM_writeReg(wreg),
    .pcSrc(pc4), .branchTarget(bt4), .mem_stall(st4),
    .MEMWB_wb(owb4), .MEMWB_readData(ord4),
    .MEMWB_aluResult(oal4), .MEMWB_writeReg(owr4)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0]  w,
                       input logic [2:0]  mm,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [4:0]  r);
    wb    = w;
    m     = mm;
    alu   = a;
    wdata = d;
    wreg  = r;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clock  = 1'b0;
    reset2 = 1'b0;
    reset4 = 1'b0;
    target = 32'd0;
    zero   = 1'b0;
    drive(2'b00, 3'b000, 32'd0, 32'd0, 5'd0);

    // reset
    tick;
    tick;
    chk("rst_wb", 32'(owb2), 32'd0);
    chk("rst_rd", ord2, 32'd0);
    chk("rst_alu", oal2, 32'd0);
    chk("rst_wr", 32'(owr2), 32'd0);
    chk("rst_stall", 32'(st2), 32'd0);
    chk("rst4_wb", 32'(owb4), 32'd0);
    reset2 = 1'b1;
    #1;
    chk("rel_stall", 32'(st2), 32'd0);

    // R-type: no stall, single cycle
    drive(2'b10, 3'b000, 32'h55, 32'h0, 5'd3);
    chk("r_stall", 32'(st2), 32'd0);
    tick;
    chk("r_alu", oal2, 32'h55);
    chk("r_rd", ord2, 32'd0);
    chk("r_wb", 32'(owb2), 32'd2);
    chk("r_wr", 32'(owr2), 32'd3);

    // store 0x10 <- DEADBEEF
    drive(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0);
    chk("st_stall0", 32'(st2), 32'd1);
    tick;
    chk("st_bubble", 32'(owb2), 32'd0);
    chk("st_hold", oal2, 32'h55);
    chk("st_stall1", 32'(st2), 32'd0);
    tick;
    chk("st_alu", oal2, 32'h10);
    chk("st_rd", ord2, 32'd0);

    // load 0x13 (byte offset ignored)
    drive(2'b11, 3'b010, 32'h13, 32'h0, 5'd8);
    chk("ld_stall0", 32'(st2), 32'd1);
    tick;
    chk("ld_bubble", 32'(owb2), 32'd0);
    chk("ld_stall1", 32'(st2), 32'd0);
    tick;
    chk("ld_rd", ord2, 32'hDEADBEEF);
    chk("ld_wr", 32'(owr2), 32'd8);
    chk("ld_wb", 32'(owb2), 32'd3);
    chk("ld_alu", oal2, 32'h13);

    // wrapped address 0x1010 -> word 4
    drive(2'b11, 3'b010, 32'h1010, 32'h0, 5'd9);
    tick;
    tick;
    chk("wrap_rd", ord2, 32'hDEADBEEF);

    // read+write: returns old word, stores new
    drive(2'b11, 3'b011, 32'h10, 32'h12345678, 5'd4);
    tick;
    tick;
    chk("rw_rd", ord2, 32'hDEADBEEF);
    drive(2'b11, 3'b010, 32'h10, 32'h0, 5'd4);
    tick;
    tick;
    chk("rw_after", ord2, 32'h12345678);

    // branch resolve
    target = 32'h40;
    zero   = 1'b1;
    drive(2'b00, 3'b100, 32'h0, 32'h0, 5'd0);
    chk("br_pc", 32'(pc2), 32'd1);
    chk("br_tgt", bt2, 32'h40);
    chk("br_stall", 32'(st2), 32'd0);
    zero = 1'b0;
    #1;
    chk("br_nz", 32'(pc2), 32'd0);
    tick;
    chk("br_rd", ord2, 32'd0);
    target = 32'd0;

    // latency 4: baseline store 0x20 <- 11111111
    reset2 = 1'b0;
    drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    tick;
    reset4 = 1'b1;
    drive(2'b00, 3'b001, 32'h20, 32'h11111111, 5'd0);
    chk("l4_s0", 32'(st4), 32'd1);
    tick;
    chk("l4_s1", 32'(st4), 32'd1);
    tick;
    chk("l4_s2", 32'(st4), 32'd1);
    tick;
    chk("l4_s3", 32'(st4), 32'd0);
    tick;
    chk("l4_alu", oal4, 32'h20);

    // store aborted by reset in 2nd stall cycle
    drive(2'b00, 3'b001, 32'h20, 32'h22222222, 5'd0);
    tick;
    chk("ab_stall", 32'(st4), 32'd1);
    reset4 = 1'b0;
    drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    tick;
    chk("ab_alu", oal4, 32'd0);
    chk("ab_wb", 32'(owb4), 32'd0);
    chk("ab_stall0", 32'(st4), 32'd0);
    reset4 = 1'b1;

    // load back: baseline word must survive
    drive(2'b11, 3'b010, 32'h20, 32'h0, 5'd5);
    tick;
    chk("l4_bub", 32'(owb4), 32'd0);
    tick;
    tick;
    chk("l4_pend", 32'(st4), 32'd0);
    tick;
    chk("ab_rd", ord4, 32'h11111111);
    chk("l4_wr", 32'(owr4), 32'd5);
    chk("l4_wb", 32'(owb4), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
